// File: rtl/l2_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : l2_port_arbiter
//  Purpose  : Shares the L2 CPU-side line port between the L1 I-cache and the
//             L1 D-cache. One 256-bit line transaction at a time, round-robin
//             on conflicts, address/write data registered at grant.
//  Options  : ARB_STATS_EN - adds grant and conflict statistics counters.
//  Revision : 1.0 - initial release
// ============================================================================
module l2_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_d;     // 1: most recent grant went to the D-cache
  logic              r_op_write;   // latched operation of the current transaction
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_i_rdata;
  logic [LINE_W-1:0] r_d_rdata;
  logic              w_i_req;
  logic              w_d_req;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_conflict;

  assign w_i_req    = i_read;
  assign w_d_req    = d_read | d_write;
  assign w_conflict = (r_state == ST_IDLE) && w_i_req && w_d_req;

  // Next-state, grant decision and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    l2_read     = 1'b0;
    l2_write    = 1'b0;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // On a conflict the side that did not win last time goes first
        if (w_i_req && (!w_d_req || r_last_d)) begin
          w_grant_i   = 1'b1;
          w_state_nxt = ST_SERVE_I;
        end else if (w_d_req) begin
          w_grant_d   = 1'b1;
          w_state_nxt = ST_SERVE_D;
        end
      end
      ST_SERVE_I: begin
        l2_read  = ~r_op_write;
        l2_write = r_op_write;
        if (l2_resp) begin
          i_resp      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_SERVE_D: begin
        l2_read  = ~r_op_write;
        l2_write = r_op_write;
        if (l2_resp) begin
          d_resp      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // Turnaround cycle lets the requester drop its request
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and round-robin history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_last_d <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_i) r_last_d <= 1'b0;
      if (w_grant_d) r_last_d <= 1'b1;
    end
  end

  // Request capture at grant; d_write dominates an illegal read+write request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else if (w_grant_i) begin
      r_op_write <= 1'b0;
      r_addr     <= i_addr;
    end else if (w_grant_d) begin
      r_op_write <= d_write;
      r_addr     <= d_addr;
      r_wdata    <= d_wdata;
    end
  end

  // Hold the last returned line per requester between completions
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (i_resp) r_i_rdata <= l2_rdata;
      if (d_resp) r_d_rdata <= l2_rdata;
    end
  end

  assign l2_addr  = r_addr;
  assign l2_wdata = r_wdata;
  assign i_rdata  = i_resp ? l2_rdata : r_i_rdata;
  assign d_rdata  = d_resp ? l2_rdata : r_d_rdata;

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] r_i_grant_cnt;
  logic [CNT_W-1:0] r_d_grant_cnt;
  logic [CNT_W-1:0] r_conflict_cnt;
  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

  // Free-running statistics, wrapping naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i_grant_cnt  <= '0;
      r_d_grant_cnt  <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_grant_i)  r_i_grant_cnt  <= r_i_grant_cnt + c_one;
      if (w_grant_d)  r_d_grant_cnt  <= r_d_grant_cnt + c_one;
      if (w_conflict) r_conflict_cnt <= r_conflict_cnt + c_one;
    end
  end

  assign i_grant_cnt  = r_i_grant_cnt;
  assign d_grant_cnt  = r_d_grant_cnt;
  assign conflict_cnt = r_conflict_cnt;
`else
  logic w_unused_conflict;
  assign w_unused_conflict = w_conflict;
  assign i_grant_cnt       = '0;
  assign d_grant_cnt       = '0;
  assign conflict_cnt      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_l2_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l2_port_arbiter
//  Purpose  : Scoreboard bench for l2_port_arbiter with randomized requesters,
//             an L2 responder model and a response monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_l2_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int CNT_W  = 32;
`ifdef ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_read = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;
  logic [CNT_W-1:0]  i_grant_cnt;
  logic [CNT_W-1:0]  d_grant_cnt;
  logic [CNT_W-1:0]  conflict_cnt;

  l2_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              is_d;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
  } txn_t;

  txn_t exp_l2[$];     // order in which the L2 should see transactions
  txn_t exp_resp[$];   // order in which completions should reach the caches
  txn_t i_list[$];     // work for the I-side requester
  txn_t d_list[$];     // work for the D-side requester

  int tests  = 0;
  int errors = 0;

  // Reference model state
  bit               model_last_d = 1'b1;
  int               exp_ig = 0, exp_dg = 0, exp_cf = 0;
  logic [LINE_W-1:0] last_i = '0, last_d = '0;

  // Controls for the L2 responder
  bit l2_en = 1'b0;
  int lat_force = 0;
  int spur_cnt = 0, spur_done = 0;
  bit scramble = 1'b0;
  bit illegal = 1'b0;

  function automatic void check(string name, logic [LINE_W-1:0] act, logic [LINE_W-1:0] expv);
    tests++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic txn_t mk(bit is_d, bit wr);
    txn_t t;
    t.is_d  = is_d;
    t.wr    = wr;
    t.addr  = {$urandom} & 32'hFFFF_FFE0;
    t.wdata = rand_line();
    t.rdata = rand_line();
    return t;
  endfunction

  // L2 responder: checks each new request against the expected order,
  // answers after a random latency, and injects spurious responses on demand
  initial begin : l2_model
    txn_t t;
    int   lat;
    l2_resp  = 1'b0;
    l2_rdata = '0;
    forever begin
      @(negedge clk);
      if (l2_en && (l2_read || l2_write)) begin
        check("l2_one_hot", {255'd0, l2_read & l2_write}, '0);
        if (exp_l2.size() == 0) begin
          errors++;
          tests++;
          $display("FAIL l2_unexpected: got addr %h expected no request", l2_addr);
        end else begin
          t = exp_l2.pop_front();
          check("l2_write", {255'd0, l2_write}, {255'd0, t.wr});
          check("l2_read", {255'd0, l2_read}, {255'd0, ~t.wr});
          check("l2_addr", {224'd0, l2_addr}, {224'd0, t.addr});
          if (t.wr) check("l2_wdata", l2_wdata, t.wdata);
          lat = (lat_force != 0) ? lat_force : int'($urandom_range(1, 4));
          repeat (lat) @(posedge clk);
          #1;
          l2_resp  = 1'b1;
          l2_rdata = t.rdata;
          @(negedge clk);
          check("l2_addr_hold", {224'd0, l2_addr}, {224'd0, t.addr});
          check("l2_req_hold", {254'd0, l2_read, l2_write}, {254'd0, ~t.wr, t.wr});
          @(posedge clk);
          #1;
          l2_resp  = 1'b0;
          l2_rdata = rand_line();
        end
      end else if (spur_done != spur_cnt && !l2_read && !l2_write) begin
        @(posedge clk);
        #1;
        l2_resp  = 1'b1;
        l2_rdata = rand_line();
        @(negedge clk);
        check("spur_resp", {254'd0, i_resp, d_resp}, '0);
        check("spur_i_rdata", i_rdata, last_i);
        check("spur_d_rdata", d_rdata, last_d);
        @(posedge clk);
        #1;
        l2_resp = 1'b0;
        spur_done++;
      end
    end
  end

  // Response monitor: every completion pulse must match the next expected one
  initial begin : resp_monitor
    txn_t t;
    forever begin
      @(negedge clk);
      if (i_resp || d_resp) begin
        check("resp_exclusive", {255'd0, i_resp & d_resp}, '0);
        if (exp_resp.size() == 0) begin
          errors++;
          tests++;
          $display("FAIL resp_unexpected: got i_resp=%0b d_resp=%0b expected none", i_resp, d_resp);
        end else begin
          t = exp_resp.pop_front();
          check("resp_side", {255'd0, d_resp}, {255'd0, t.is_d});
          check("resp_rdata", t.is_d ? d_rdata : i_rdata, t.rdata);
          if (t.is_d) last_d = t.rdata; else last_i = t.rdata;
        end
      end
    end
  end

  task automatic wait_resp(bit is_d);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_d ? d_resp : i_resp) && n < 80);
    if (!(is_d ? d_resp : i_resp)) begin
      errors++;
      tests++;
      $display("FAIL resp_timeout: got no %s response expected one within 80 cycles", is_d ? "D" : "I");
    end
  endtask

  task automatic drive_i();
    txn_t t;
    while (i_list.size() > 0) begin
      t = i_list.pop_front();
      i_read = 1'b1;
      i_addr = t.addr;
      wait_resp(1'b0);
      @(posedge clk);
      #1;
    end
    i_read = 1'b0;
  endtask

  task automatic drive_d();
    txn_t t;
    while (d_list.size() > 0) begin
      t = d_list.pop_front();
      d_write = t.wr;
      d_read  = ~t.wr | illegal;
      d_addr  = t.addr;
      d_wdata = t.wdata;
      if (scramble) begin
        @(posedge clk);
        #1;
        d_addr  = ~t.addr;
        d_wdata = rand_line();
      end
      wait_resp(1'b1);
      @(posedge clk);
      #1;
    end
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  // Predict service order from the round-robin rule, then run the requesters
  task automatic run_phase();
    txn_t ic[$];
    txn_t dc[$];
    bit   next_d;
    ic = i_list;
    dc = d_list;
    if (ic.size() > 0 && dc.size() > 0) exp_cf += ic.size() + dc.size() - 1;
    next_d = (ic.size() == 0) ? 1'b1 : (dc.size() == 0) ? 1'b0 : ~model_last_d;
    while (ic.size() + dc.size() > 0) begin
      if (next_d && dc.size() > 0) begin
        exp_l2.push_back(dc[0]);
        exp_resp.push_back(dc.pop_front());
        exp_dg++;
        model_last_d = 1'b1;
      end else begin
        exp_l2.push_back(ic[0]);
        exp_resp.push_back(ic.pop_front());
        exp_ig++;
        model_last_d = 1'b0;
      end
      next_d = ~next_d;
    end
    @(posedge clk);
    #1;
    fork
      drive_i();
      drive_d();
    join
    repeat (3) @(negedge clk);
    check("exp_l2_drained", 256'(exp_l2.size()), '0);
    check("exp_resp_drained", 256'(exp_resp.size()), '0);
    check("i_grant_cnt", 256'(i_grant_cnt), STATS ? 256'(exp_ig) : '0);
    check("d_grant_cnt", 256'(d_grant_cnt), STATS ? 256'(exp_dg) : '0);
    check("conflict_cnt", 256'(conflict_cnt), STATS ? 256'(exp_cf) : '0);
    scramble = 1'b0;
    illegal  = 1'b0;
  endtask

  initial begin : main
    txn_t t;
    int   kind;
    int   n;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_l2_req", {254'd0, l2_read, l2_write}, '0);
    check("rst_resp", {254'd0, i_resp, d_resp}, '0);
    check("rst_l2_addr", {224'd0, l2_addr}, '0);
    check("rst_l2_wdata", l2_wdata, '0);
    check("rst_i_rdata", i_rdata, '0);
    check("rst_d_rdata", d_rdata, '0);
    check("rst_cnts", {160'd0, i_grant_cnt, d_grant_cnt, conflict_cnt}, '0);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    l2_en = 1'b1;

    // Both caches read out of reset: I first, then D
    i_list.push_back(mk(1'b0, 1'b0));
    d_list.push_back(mk(1'b1, 1'b0));
    run_phase();

    // Reset in the middle of a D writeback
    l2_en = 1'b0;
    @(posedge clk);
    #1;
    d_write = 1'b1;
    d_addr  = 32'h0000_2000;
    d_wdata = rand_line();
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_l2_write", {255'd0, l2_write}, 256'd1);
    #2 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_l2_write", {255'd0, l2_write}, '0);
    check("mid_rst_d_resp", {255'd0, d_resp}, '0);
    check("mid_rst_l2_addr", {224'd0, l2_addr}, '0);
    d_write = 1'b0;
    model_last_d = 1'b1;
    exp_ig = 0; exp_dg = 0; exp_cf = 0;
    last_i = '0; last_d = '0;
    @(posedge clk);
    #1;
    rst   = 1'b1;
    l2_en = 1'b1;

    // Directed single I read with a 4-cycle L2 latency
    t = mk(1'b0, 1'b0);
    t.addr  = 32'h0000_1040;
    t.rdata = {32{8'hA5}};
    i_list.push_back(t);
    lat_force = 4;
    run_phase();
    lat_force = 0;

    // Directed D writeback with the write line changed after grant
    t = mk(1'b1, 1'b1);
    t.wdata = {16{16'h1234}};
    d_list.push_back(t);
    scramble = 1'b1;
    run_phase();

    // Illegal d_read+d_write: must go out as a write
    d_list.push_back(mk(1'b1, 1'b1));
    illegal = 1'b1;
    run_phase();

    // Spurious L2 response while idle
    spur_cnt++;
    n = 0;
    while (spur_done != spur_cnt && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("spur_done", 256'(spur_done), 256'(spur_cnt));

    // Both held continuously for four transactions
    i_list.push_back(mk(1'b0, 1'b0));
    i_list.push_back(mk(1'b0, 1'b0));
    d_list.push_back(mk(1'b1, 1'b0));
    d_list.push_back(mk(1'b1, 1'b1));
    run_phase();

    // Randomized phases
    for (int p = 0; p < 24; p++) begin
      kind = int'($urandom_range(0, 3));
      n = (kind == 3) ? int'($urandom_range(2, 3)) : 1;
      if (kind != 1) for (int k = 0; k < n; k++) i_list.push_back(mk(1'b0, 1'b0));
      if (kind != 0) for (int k = 0; k < n; k++) d_list.push_back(mk(1'b1, 1'($urandom_range(0, 1))));
      scramble = (kind == 1) && ($urandom_range(0, 1) == 1);
      illegal  = ($urandom_range(0, 3) == 0);
      run_phase();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin : watchdog
    #300000;
    errors++;
    $display("FAIL watchdog: got no completion expected finish before 300000 time units");
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire
